// File: rtl/my_ram4_if.sv
`default_nettype none
// ============================================================================
//  Module      : my_ram4_if
//  Description : Bus bundle for the four-word register bank: write data, load
//                strobe, shared address, bulk clear, and readback/status.
//  Revision    : 1.0  initial release
// ============================================================================
interface my_ram4_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in;
  logic             load;
  logic [1:0]       address;
  logic             clear;
  logic [WIDTH-1:0] out;
  logic [3:0]       written;
  logic [7:0]       load_count;

  // Requester side: drives commands, observes data and status
  modport master (
    output in, load, address, clear,
    input  out, written, load_count
  );

  // Memory side: accepts commands, presents data and status
  modport slave (
    input  in, load, address, clear,
    output out, written, load_count
  );
endinterface
`default_nettype wire

// File: rtl/my_ram4.sv
`default_nettype none
// ============================================================================
//  Module      : my_ram4 (with helper my_dmux_4_way)
//  Description : Four-word WIDTH-bit register bank. The load strobe is routed
//                through a 4-way demux into per-word enables; readback is a
//                combinational 4-way mux on the same address. Tracks which
//                words were written and a saturating count of writes.
//  Revision    : 1.0  initial release
// ============================================================================

// 1-to-4 demultiplexer: copies i_in onto the output selected by i_sel.
module my_dmux_4_way (
  input  wire logic       i_in,
  input  wire logic [1:0] i_sel,
  output logic [3:0]      o_out
);
  localparam logic [3:0] c_ONE_HOT_BASE = 4'b0001;

  // Exactly one output follows i_in; the other three stay low
  always_comb begin
    o_out = {4{i_in}} & (c_ONE_HOT_BASE << i_sel);
  end
endmodule

module my_ram4 #(
  parameter int WIDTH = 16
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  my_ram4_if.slave   bus
);
  localparam logic [7:0] c_COUNT_MAX = 8'hFF;

  logic [WIDTH-1:0] r_word [4];
  logic [3:0]       r_written;
  logic [7:0]       r_load_count;
  logic [3:0]       w_word_en;

  my_dmux_4_way u_dmux (
    .i_in  (bus.load),
    .i_sel (bus.address),
    .o_out (w_word_en)
  );

  // Storage update: reset beats clear, clear discards any coincident load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_word[i] <= '0;
      r_written    <= 4'b0000;
      r_load_count <= 8'd0;
    end else if (bus.clear) begin
      for (int i = 0; i < 4; i++) r_word[i] <= '0;
      r_written    <= 4'b0000;
      r_load_count <= 8'd0;
    end else if (bus.load) begin
      for (int i = 0; i < 4; i++) begin
        if (w_word_en[i]) begin
          r_word[i]    <= bus.in;
          r_written[i] <= 1'b1;
        end
      end
      if (r_load_count != c_COUNT_MAX) r_load_count <= r_load_count + 8'd1;
    end
  end

  // Zero-latency readback; a same-cycle write becomes visible only after the edge
  always_comb begin
    bus.out        = r_word[bus.address];
    bus.written    = r_written;
    bus.load_count = r_load_count;
  end
endmodule
`default_nettype wire

// File: doc/my_ram4.md
Name: my_ram4

Overview:
- Four-word, WIDTH-bit register bank with one write port and one read port, in the RAM8 style of the nand2tetris memory hierarchy.
- Consumes the per-word load strobes of a 4-way demux: the single load is routed through one my_dmux_4_way instance (select = address) into four word registers.
- Readback is a 4-way word mux on the same address.
- Adds a per-word written mask and a synchronous bulk clear, used by the RAM-level benches to detect reads of never-written words.

Parameters:
- WIDTH, 16, data width of each word and of in/out.

Ports:
- clk  input  1  rising-edge clock; all state updates on it.
- rst_n  input  1  synchronous active-low reset.
- in  input  WIDTH  write data.
- load  input  1  write enable for the word selected by address.
- address  input  2  word select for both write and read.
- clear  input  1  synchronous clear of all words and the written mask.
- out  output  WIDTH  contents of word[address].
- written  output  4  bit i = 1 once word i has been loaded since the last reset/clear.
- load_count  output  8  number of accepted writes since reset/clear; saturates at 255.

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-low: it is sampled only at a rising clk edge with rst_n = 0.
- Reset values:
  - word[0..3] = 0, written = 4'b0000, load_count = 0.
  - Therefore out = 0 for any address after reset.
- Priority at each rising edge, highest first: rst_n = 0, then clear = 1, then load = 1, then hold.
- Write:
  - With load = 1 (no reset, no clear), word[address] <= in and written[address] <= 1.
  - load_count <= load_count + 1 unless it is already 255.
  - The other three words and mask bits are unchanged.
- Load routing:
  - load enters the in port of my_dmux_4_way with sel = address.
  - Exactly one word-enable is high when load = 1; none is high when load = 0.
- Read:
  - out = word[address], purely combinational from the current address and stored words; zero-cycle read latency.
  - Same-cycle load to the same address: out shows the OLD value until the edge and the new value immediately after. No write-through bypass.
- Write latency: 1 clock.
- Clear: clear = 1 zeroes all four words, written, and load_count on the edge. Any coincident load is discarded; it neither writes nor counts.
- Reset mid-operation: rst_n = 0 at an edge overrides any load or clear in that cycle. Outputs take reset values after that edge and hold them while rst_n stays low.
- Rewriting a word: overwrites the data; its written bit stays 1; load_count still increments.
- Address changes with load = 0: out follows combinationally; no state change.
- X handling: address is assumed driven whenever load = 1. The bench never drives X on address with load = 1.

Test Plan:
- Reset then scan: rst_n = 0 for 2 edges, then rst_n = 1 and address 0..3 with load = 0 -> out = 0 on every address, written = 4'b0000, load_count = 0.
- Fill and readback: load addresses 0,1,2,3 with 16'h1111, 16'h2222, 16'h3333, 16'h4444 on consecutive edges, then read each address -> out matches per address, written = 4'b1111, load_count = 4.
- Same-cycle read/write: address = 2 holds 16'h3333; drive in = 16'hABCD with load = 1 -> out = 16'h3333 before the edge, 16'hABCD after, words 0/1/3 unchanged, load_count = 5.
- Demux isolation: after reset, load = 1 at address = 1 with in = 16'hFFFF -> written = 4'b0010, words 0/2/3 read 0, word 1 reads 16'hFFFF.
- Clear priority: from the full state, clear = 1 and load = 1 at address = 0 with in = 16'h5555 -> all words 0, written = 0, load_count = 0.
- Reset priority and saturation: issue 300 loads -> load_count = 255. Then rst_n = 0 with load = 1 at address = 3 -> all words 0, written = 0, load_count = 0.
